// File: rtl/read_burst_tracker_if.sv
// Bus bundle for the read-return tracker: issue side, DIMM data bus,
// assembled-line response stream and status outputs.
interface read_burst_tracker_if #(
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4,
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 16
);
  localparam int OUT_W = $clog2(DEPTH) + 1;

  logic                          issue_valid_in;
  logic [TAG_W-1:0]              issue_tag_in;
  logic                          issue_ready_out;
  logic [DATA_W-1:0]             dq_in;
  logic                          bursting_out;
  logic                          resp_valid_out;
  logic                          resp_ready_in;
  logic [TAG_W-1:0]              resp_tag_out;
  logic [BURST_LEN*DATA_W-1:0]   resp_data_out;
  logic [OUT_W-1:0]              outstanding_out;
  logic                          overflow_err_out;

  // Tracker side
  modport slave (
    input  issue_valid_in, issue_tag_in, dq_in, resp_ready_in,
    output issue_ready_out, bursting_out, resp_valid_out, resp_tag_out,
           resp_data_out, outstanding_out, overflow_err_out
  );

  // Controller / consumer side
  modport master (
    output issue_valid_in, issue_tag_in, dq_in, resp_ready_in,
    input  issue_ready_out, bursting_out, resp_valid_out, resp_tag_out,
           resp_data_out, outstanding_out, overflow_err_out
  );
endinterface

// File: rtl/read_burst_tracker.sv
// DDR4 read-return tracker. Each accepted READ is timestamped with a free
// running cycle counter; BURST_LEN beats are sampled from the data bus
// starting CAS_LATENCY edges after issue and the assembled line is queued
// in a small output FIFO with valid/ready backpressure. Issues are spaced
// at least BURST_LEN edges apart, so bursts never overlap and only the
// tracker head can be bursting. DEPTH and OUT_DEPTH must be powers of two
// and at least 2.
module read_burst_tracker #(
  parameter int CAS_LATENCY = 22,
  parameter int BURST_LEN   = 8,
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 4,
  parameter int OUT_DEPTH   = 2,
  parameter int CNT_W       = 32
) (
  input logic             clk_in,
  input logic             rst_in,
  read_burst_tracker_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int OAW    = $clog2(OUT_DEPTH);
  localparam int BW     = $clog2(BURST_LEN);
  localparam int GW     = $clog2(BURST_LEN + 1);
  localparam int LINE_W = BURST_LEN * DATA_W;

  localparam logic [CNT_W-1:0] FIRST_AGE = CNT_W'(CAS_LATENCY);
  localparam logic [CNT_W-1:0] LAST_AGE  = CNT_W'(CAS_LATENCY + BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [GW-1:0]    GAP_FULL  = GW'(BURST_LEN);
  localparam logic [GW-1:0]    GAP_ONE   = GW'(1);
  localparam logic [AW:0]      TRK_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      TRK_ONE   = (AW+1)'(1);
  localparam logic [OAW:0]     OUT_FULL  = (OAW+1)'(OUT_DEPTH);
  localparam logic [OAW:0]     OUT_ONE   = (OAW+1)'(1);

  // Control state (reset)
  logic [CNT_W-1:0] cyc_q;
  logic [GW-1:0]    gap_q, gap_d;
  logic [AW:0]      trk_wr_q, trk_rd_q;
  logic [OAW:0]     out_wr_q, out_rd_q;
  logic             ovf_q;

  // Data storage (no reset: always written before it can be observed)
  logic [TAG_W-1:0]                  trk_tag_mem [DEPTH];
  logic [CNT_W-1:0]                  trk_ts_mem  [DEPTH];
  logic [BURST_LEN-1:0][DATA_W-1:0]  line_q, line_d;
  logic [TAG_W-1:0]                  out_tag_mem  [OUT_DEPTH];
  logic [LINE_W-1:0]                 out_data_mem [OUT_DEPTH];

  logic [AW:0]      trk_cnt;
  logic             trk_empty, trk_full;
  logic [CNT_W-1:0] head_ts, age;
  logic [TAG_W-1:0] head_tag;
  logic [BW-1:0]    beat;
  logic             burst, last_beat;
  logic             issue_ready, accept;
  logic [OAW:0]     out_cnt;
  logic             out_empty, out_full;
  logic             resp_valid, resp_pop, out_push, line_drop;

  // Tracker occupancy and head age; age is modular so counter wrap is harmless
  assign trk_cnt   = trk_wr_q - trk_rd_q;
  assign trk_empty = (trk_cnt == '0);
  assign trk_full  = (trk_cnt == TRK_FULL);
  assign head_ts   = trk_ts_mem[trk_rd_q[AW-1:0]];
  assign head_tag  = trk_tag_mem[trk_rd_q[AW-1:0]];
  assign age       = cyc_q - head_ts;
  assign burst     = !trk_empty && (age >= FIRST_AGE) && (age <= LAST_AGE);
  assign beat      = BW'(age - FIRST_AGE);
  assign last_beat = burst && (age == LAST_AGE);

  assign issue_ready = !trk_full && (gap_q == GAP_FULL);
  assign accept      = bus.issue_valid_in && issue_ready;

  // Output FIFO; a pop on the completion edge frees the slot for the new line
  assign out_cnt    = out_wr_q - out_rd_q;
  assign out_empty  = (out_cnt == '0);
  assign out_full   = (out_cnt == OUT_FULL);
  assign resp_valid = !out_empty;
  assign resp_pop   = resp_valid && bus.resp_ready_in;
  assign out_push   = last_beat && (!out_full || resp_pop);
  assign line_drop  = last_beat && out_full && !resp_pop;

  assign bus.issue_ready_out  = issue_ready;
  assign bus.bursting_out     = burst;
  assign bus.resp_valid_out   = resp_valid;
  // Head contents are masked when empty so the idle/reset value is zero
  assign bus.resp_tag_out     = resp_valid ? out_tag_mem[out_rd_q[OAW-1:0]]  : '0;
  assign bus.resp_data_out    = resp_valid ? out_data_mem[out_rd_q[OAW-1:0]] : '0;
  assign bus.outstanding_out  = trk_cnt;
  assign bus.overflow_err_out = ovf_q;

  // Merge the beat on the bus into the line being assembled
  always_comb begin
    line_d = line_q;
    if (burst) begin
      line_d[beat] = bus.dq_in;
    end
  end

  // Issue spacing: restart on accept, otherwise count up to BURST_LEN
  always_comb begin
    gap_d = gap_q;
    if (accept) begin
      gap_d = GAP_ONE;
    end else if (gap_q != GAP_FULL) begin
      gap_d = gap_q + GAP_ONE;
    end
  end

  // Control registers: counter, spacing, FIFO pointers, sticky overflow
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_q    <= '0;
      gap_q    <= GAP_FULL;
      trk_wr_q <= '0;
      trk_rd_q <= '0;
      out_wr_q <= '0;
      out_rd_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cyc_q <= cyc_q + CNT_ONE;
      gap_q <= gap_d;
      if (accept)    trk_wr_q <= trk_wr_q + TRK_ONE;
      if (last_beat) trk_rd_q <= trk_rd_q + TRK_ONE;
      if (out_push)  out_wr_q <= out_wr_q + OUT_ONE;
      if (resp_pop)  out_rd_q <= out_rd_q + OUT_ONE;
      if (line_drop) ovf_q    <= 1'b1;
    end
  end

  // Data path: request records, line assembly and completed-line storage.
  // A stale partial line left by reset is never seen: the next burst
  // rewrites every beat before its line is pushed.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      trk_tag_mem[trk_wr_q[AW-1:0]] <= bus.issue_tag_in;
      trk_ts_mem[trk_wr_q[AW-1:0]]  <= cyc_q;
    end
    line_q <= line_d;
    if (out_push) begin
      out_tag_mem[out_wr_q[OAW-1:0]]  <= head_tag;
      out_data_mem[out_wr_q[OAW-1:0]] <= line_d;
    end
  end
endmodule

// File: doc/read_burst_tracker.md
# read_burst_tracker

Parametrised read-return path for the DDR4 memory controller, sitting between the command issue stage and the DIMM data bus. It records each accepted READ with a timestamp and samples `BURST_LEN` beats from the data bus starting exactly `CAS_LATENCY` cycles after issue. Each completed burst is assembled into a tagged line and held in an output FIFO with valid/ready backpressure. It also enforces burst spacing at issue and flags dropped lines.

## Interface
- `CAS_LATENCY`, 22: cycles from issue edge to first data-beat sample edge; ≥1.
- `BURST_LEN`, 8: beats per read; ≥2.
- `DATA_W`, 64: data bus width.
- `DEPTH`, 16: maximum outstanding reads; power of two.
- `TAG_W`, 4: request tag width.
- `OUT_DEPTH`, 2: assembled-line FIFO entries; power of two.
- `CNT_W`, 32: timestamp/cycle counter width; must satisfy 2^CNT_W > CAS_LATENCY+BURST_LEN.

Ports:
- `clk_in`  in  1  clock; all state on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `issue_valid_in`  in  1  READ being issued to DIMM this cycle.
- `issue_tag_in`  in  TAG_W  tag of the issued read.
- `issue_ready_out`  out  1  read may be issued (combinational).
- `dq_in`  in  DATA_W  DIMM data bus.
- `bursting_out`  out  1  `dq_in` is sampled at the coming edge (combinational).
- `resp_valid_out`  out  1  assembled line available.
- `resp_ready_in`  in  1  consumer takes the line.
- `resp_tag_out`  out  TAG_W  tag of the head line.
- `resp_data_out`  out  BURST_LEN*DATA_W  head line; beat k at bits [k*DATA_W +: DATA_W].
- `outstanding_out`  out  $clog2(DEPTH)+1  reads issued but not fully sampled.
- `overflow_err_out`  out  1  sticky: a completed line was dropped.

## Operation
- Free-running `cyc` counter, CNT_W bits, +1 every edge, wraps modulo 2^CNT_W.
- Accept = `issue_valid_in && issue_ready_out`. On accept, push {tag, ts=cyc} into tracker FIFO (DEPTH). `issue_valid_in` without ready is ignored, with no state change.
- Spacing counter `gap`: set to 1 on accept, otherwise +1 saturating at BURST_LEN. Reset value is BURST_LEN.
- `issue_ready_out = (outstanding < DEPTH) && (gap == BURST_LEN)`. Accepted issues are therefore ≥BURST_LEN cycles apart, so bursts never overlap and completion is in order.
- Head age `age = (cyc - head.ts) mod 2^CNT_W`. `bursting_out = !tracker_empty && CAS_LATENCY ≤ age ≤ CAS_LATENCY+BURST_LEN-1`.
- While `bursting_out` is high, each edge writes `dq_in` into beat `age-CAS_LATENCY` of the assembly register.
- On the edge where `age == CAS_LATENCY+BURST_LEN-1`:
  - pop the tracker;
  - write {tag, line including that final beat} to the output FIFO.
- If the output FIFO is full on that edge and no pop occurs on the same edge, drop the line and set `overflow_err_out`. If a pop occurs on the same edge, the write succeeds.
- Output FIFO pop = `resp_valid_out && resp_ready_in`. `resp_valid_out` = FIFO not empty. Tag and data come from the head entry and are stable while valid and not ready.
- Simultaneous accept and tracker pop on one edge: `outstanding_out` is unchanged.

## Timing
- Reset values: `issue_ready_out`=1, `bursting_out`=0, `resp_valid_out`=0, `resp_tag_out`=0, `resp_data_out`=0, `outstanding_out`=0, `overflow_err_out`=0, `cyc`=0.
- Reset mid-burst or mid-stream clears the tracker, partial assembly and output FIFO with no response emitted. `gap` returns to BURST_LEN.
- For a read accepted at edge E:
  - beat k is sampled at edge E+CAS_LATENCY+k;
  - `resp_valid_out` rises after edge E+CAS_LATENCY+BURST_LEN-1;
  - total latency is CAS_LATENCY+BURST_LEN edges.
- Next issue is earliest at edge E+BURST_LEN.
- Counter wrap: age arithmetic is modular. Timestamps straddling a wrap behave identically.
- `overflow_err_out` holds until `rst_in`.

## Test plan
- Single read, tag 3, accepted at edge 0, with `dq_in` = beat index+0xA0 during the burst → `bursting_out` high for 8 cycles before edges 22..29. `resp_valid_out` rises after edge 29 with tag 3 and beats 0xA0..0xA7 in order.
- Valid held every cycle → accepts at edges 0, 8, 16, …, `issue_ready_out` low in between. Responses arrive back-to-back with tags in issue order.
- DEPTH=4, CAS_LATENCY=40 → 4 accepts, then `issue_ready_out` stays low until the first tracker pop. `outstanding_out` reads 4, then 3, and the 5th read is accepted.
- `resp_ready_in`=0 with OUT_DEPTH=2 and 3 reads → first two lines held, third dropped, `overflow_err_out`=1. Repeat with ready pulsed exactly on the third line's completion edge → no drop.
- `rst_in` asserted at beat 4 of a burst → all outputs at reset values immediately. No response after release. A new read then completes normally.
- CNT_W=6, read accepted with `cyc`=60 → beats sampled across the wrap at the correct edges and the data is intact.
